// File: rtl/bp_update_scheduler_if.sv
// Commit-lane bundle between the RoB (master) and the branch-update scheduler (slave).
// Lane 0 is always the older of the two commits; in_ready is shared by both lanes.
interface bp_update_scheduler_if;
    logic        in0_valid;
    logic [31:0] in0_pc;
    logic        in0_taken;
    logic        in1_valid;
    logic [31:0] in1_pc;
    logic        in1_taken;
    logic        in_ready;

    modport master (
        output in0_valid, in0_pc, in0_taken,
        output in1_valid, in1_pc, in1_taken,
        input  in_ready
    );

    modport slave (
        input  in0_valid, in0_pc, in0_taken,
        input  in1_valid, in1_pc, in1_taken,
        output in_ready
    );
endinterface

// File: rtl/bp_update_scheduler.sv
// Branch-update scheduler: merges up to two branch outcomes per cycle from the RoB
// commit lanes into a FIFO and drains one per cycle onto the single predictor
// update port. An empty FIFO is bypassed so a lone update costs no extra cycle.
module bp_update_scheduler #(
    parameter int DEPTH_LOG = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    bp_update_scheduler_if.slave   commit,
    output logic                   bp_update_en,
    output logic [31:0]            bp_update_PC,
    output logic                   bp_update_result,
    output logic [DEPTH_LOG:0]     occupancy,
    output logic [31:0]            issued_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef logic [DEPTH_LOG-1:0] ptr_t;
    typedef logic [DEPTH_LOG:0]   cnt_t;

    // Entry layout: {taken, pc}
    logic [32:0] entry_q [DEPTH];

    ptr_t        head_reg, tail_reg;
    cnt_t        count_reg;
    logic        en_reg;
    logic [31:0] pc_reg;
    logic        result_reg;
    logic [31:0] issued_reg;

    ptr_t        head_next, tail_next, tail_plus1;
    cnt_t        count_next;

    logic        acc0, acc1, pop;
    logic [32:0] lane0, lane1;
    logic        slot0_we, slot1_we;
    logic [32:0] slot0_data, slot1_data;
    logic        load_en;
    logic [32:0] load_data;

    // Room for two more entries guarantees both lanes always fit, even without a pop.
    assign commit.in_ready = (count_reg <= cnt_t'(DEPTH - 2));

    // Decide what leaves for the predictor and what gets queued this cycle.
    always_comb begin
        lane0      = {commit.in0_taken, commit.in0_pc};
        lane1      = {commit.in1_taken, commit.in1_pc};
        acc0       = rdy_in & commit.in_ready & commit.in0_valid;
        acc1       = rdy_in & commit.in_ready & commit.in1_valid;
        pop        = rdy_in & (count_reg != '0);
        slot0_we   = 1'b0;
        slot1_we   = 1'b0;
        slot0_data = lane0;
        slot1_data = lane1;
        load_en    = 1'b0;
        load_data  = entry_q[head_reg];
        if (pop) begin
            // Queued entries are older than anything arriving now.
            load_en = 1'b1;
            if (acc0) begin
                slot0_we   = 1'b1;
                slot0_data = lane0;
                slot1_we   = acc1;
                slot1_data = lane1;
            end else if (acc1) begin
                slot0_we   = 1'b1;
                slot0_data = lane1;
            end
        end else if (acc0) begin
            // Empty FIFO: lane 0 bypasses, lane 1 (if any) waits one cycle.
            load_en    = 1'b1;
            load_data  = lane0;
            slot0_we   = acc1;
            slot0_data = lane1;
        end else if (acc1) begin
            load_en   = 1'b1;
            load_data = lane1;
        end
        tail_plus1 = tail_reg + ptr_t'(1);
        head_next  = head_reg + ptr_t'(pop);
        tail_next  = tail_reg + ptr_t'(slot0_we) + ptr_t'(slot1_we);
        count_next = count_reg + cnt_t'(slot0_we) + cnt_t'(slot1_we) - cnt_t'(pop);
    end

    // Storage: slot 0 lands at tail, slot 1 (only with slot 0) at tail+1.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [32:0] entry_reg;

        // Per-entry write; contents are don't-care after reset, so no clear.
        always_ff @(posedge clk_in) begin
            if (slot0_we && (tail_reg == ptr_t'(gi))) begin
                entry_reg <= slot0_data;
            end else if (slot1_we && (tail_plus1 == ptr_t'(gi))) begin
                entry_reg <= slot1_data;
            end
        end

        assign entry_q[gi] = entry_reg;
    end

    // Pointers, count and the registered predictor update port; everything holds when paused.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            en_reg     <= 1'b0;
            pc_reg     <= '0;
            result_reg <= 1'b0;
            issued_reg <= '0;
        end else if (rdy_in) begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            en_reg    <= load_en;
            if (load_en) begin
                pc_reg     <= load_data[31:0];
                result_reg <= load_data[32];
                issued_reg <= issued_reg + 32'd1;
            end
        end
    end

    assign bp_update_en     = en_reg;
    assign bp_update_PC     = pc_reg;
    assign bp_update_result = result_reg;
    assign occupancy        = count_reg;
    assign issued_cnt       = issued_reg;
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Self-checking bench for bp_update_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_bp_update_scheduler;
    localparam int DEPTH_LOG = 3;
    localparam int DEPTH     = 1 << DEPTH_LOG;

    logic                 clk_in;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 bp_update_en;
    logic [31:0]          bp_update_PC;
    logic                 bp_update_result;
    logic [DEPTH_LOG:0]   occupancy;
    logic [31:0]          issued_cnt;

    bp_update_scheduler_if cif ();

    bp_update_scheduler #(.DEPTH_LOG(DEPTH_LOG)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .commit           (cif.slave),
        .bp_update_en     (bp_update_en),
        .bp_update_PC     (bp_update_PC),
        .bp_update_result (bp_update_result),
        .occupancy        (occupancy),
        .issued_cnt       (issued_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: pending updates in commit order plus the predictor port.
    logic [32:0] m_q [$];
    logic        m_en;
    logic [31:0] m_pc;
    logic        m_res;
    logic [31:0] m_cnt;
    int unsigned pc_seq;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model and DUT, check outputs.
    task automatic step(input logic rst, input logic rdy,
                        input logic v0, input logic [31:0] p0, input logic t0,
                        input logic v1, input logic [31:0] p1, input logic t1);
        logic        exp_ready;
        logic [32:0] acc [$];
        logic [32:0] e;
        @(negedge clk_in);
        rst_in        = rst;
        rdy_in        = rdy;
        cif.in0_valid = v0;
        cif.in0_pc    = p0;
        cif.in0_taken = t0;
        cif.in1_valid = v1;
        cif.in1_pc    = p1;
        cif.in1_taken = t1;
        #1;
        exp_ready = (m_q.size() <= DEPTH - 2);
        check_val("in_ready", 32'(cif.in_ready), 32'(exp_ready));
        @(posedge clk_in);
        if (!rst) begin
            m_q.delete();
            m_en  = 1'b0;
            m_pc  = '0;
            m_res = 1'b0;
            m_cnt = '0;
        end else if (rdy) begin
            if (exp_ready && v0) acc.push_back({t0, p0});
            if (exp_ready && v1) acc.push_back({t1, p1});
            if (m_q.size() > 0 || acc.size() > 0) begin
                if (m_q.size() > 0) e = m_q.pop_front();
                else                e = acc.pop_front();
                foreach (acc[i]) m_q.push_back(acc[i]);
                m_en  = 1'b1;
                m_pc  = e[31:0];
                m_res = e[32];
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_en = 1'b0;
            end
        end
        #1;
        check_val("update_en",     32'(bp_update_en),     32'(m_en));
        check_val("update_PC",     bp_update_PC,          m_pc);
        check_val("update_result", 32'(bp_update_result), 32'(m_res));
        check_val("occupancy",     32'(occupancy),        32'(m_q.size()));
        check_val("issued_cnt",    issued_cnt,            m_cnt);
        $display("[TB] t=%0t rst=%b rdy=%b v0=%b v1=%b -> en=%b pc=%08h res=%b occ=%0d issued=%0d",
                 $time, rst, rdy, v0, v1, bp_update_en, bp_update_PC, bp_update_result,
                 occupancy, issued_cnt);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Both lanes valid with fresh, distinct PCs.
    task automatic fill(input logic rdy);
        step(1'b1, rdy, 1'b1, pc_seq, pc_seq[2], 1'b1, pc_seq + 32'd4, ~pc_seq[3]);
        pc_seq = pc_seq + 32'd8;
    endtask

    logic [31:0] pc_hold, iss_hold;

    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        cif.in0_valid = 1'b0;
        cif.in0_pc    = '0;
        cif.in0_taken = 1'b0;
        cif.in1_valid = 1'b0;
        cif.in1_pc    = '0;
        cif.in1_taken = 1'b0;
        m_en          = 1'b0;
        m_pc          = '0;
        m_res         = 1'b0;
        m_cnt         = '0;
        pc_seq        = 32'h0000_1000;

        // Reset held for two edges with a valid lane present.
        step(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("rst_en",       32'(bp_update_en), 32'd0);
        check_val("rst_pc",       bp_update_PC,      32'd0);
        check_val("rst_occ",      32'(occupancy),    32'd0);
        check_val("rst_ready",    32'(cif.in_ready), 32'd1);
        check_val("rst_issued",   issued_cnt,        32'd0);

        // Single update into an empty FIFO bypasses straight to the port.
        step(1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("byp_en",     32'(bp_update_en),     32'd1);
        check_val("byp_pc",     bp_update_PC,          32'h104);
        check_val("byp_res",    32'(bp_update_result), 32'd1);
        check_val("byp_occ",    32'(occupancy),        32'd0);
        idle();
        check_val("byp_en_off", 32'(bp_update_en),     32'd0);
        check_val("byp_issued", issued_cnt,            32'd1);

        // Two lanes at once: lane 0 bypasses, lane 1 follows one cycle later.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 1'b0);
        check_val("dual_pc0",  bp_update_PC,          32'h10);
        check_val("dual_res0", 32'(bp_update_result), 32'd1);
        check_val("dual_occ0", 32'(occupancy),        32'd1);
        idle();
        check_val("dual_pc1",  bp_update_PC,          32'h20);
        check_val("dual_res1", 32'(bp_update_result), 32'd0);
        check_val("dual_occ1", 32'(occupancy),        32'd0);
        idle();
        check_val("dual_en",   32'(bp_update_en),     32'd0);

        // Fill to DEPTH-1 with both lanes every cycle, then drain in order.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) fill(1'b1);
        check_val("full_occ",   32'(occupancy),    32'(DEPTH - 1));
        check_val("full_ready", 32'(cif.in_ready), 32'd0);
        fill(1'b1);
        check_val("full_reject_occ", 32'(occupancy), 32'(DEPTH - 2));
        for (int i = 0; i < DEPTH; i++) idle();
        check_val("drain_occ", 32'(occupancy),    32'd0);
        check_val("drain_en",  32'(bp_update_en), 32'd0);
        check_val("drain_cnt", issued_cnt,        32'(2 * (DEPTH - 1)));

        // Pause at occupancy 3 with valid inputs presented.
        do_reset();
        for (int i = 0; i < 3; i++) fill(1'b1);
        pc_hold  = bp_update_PC;
        iss_hold = issued_cnt;
        for (int i = 0; i < 3; i++) fill(1'b0);
        check_val("pause_occ",    32'(occupancy), 32'd3);
        check_val("pause_pc",     bp_update_PC,   pc_hold);
        check_val("pause_issued", issued_cnt,     iss_hold);
        for (int i = 0; i < 5; i++) idle();

        // Reset mid-drain discards everything queued.
        do_reset();
        for (int i = 0; i < 5; i++) fill(1'b1);
        check_val("pre_rst_occ", 32'(occupancy), 32'd5);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b1, 32'hBEEF, 1'b0);
        check_val("mid_rst_occ", 32'(occupancy),    32'd0);
        check_val("mid_rst_en",  32'(bp_update_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check_val("no_stale_en", 32'(bp_update_en), 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                 ($urandom_range(0, 2) != 0), $urandom, 1'($urandom));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard bound on simulated time so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
